// File: rtl/acc_sram_rd_streamer_if.sv
// Bus bundle for acc_sram_rd_streamer: the RAM read port and the output
// valid/ready stream. master = streamer side, slave = RAM + downstream side.
interface acc_sram_rd_streamer_if #(
  parameter int AW = 16,
  parameter int DW = 64
);
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;

  modport master (
    output ram_cs, ram_we, ram_addr, o_vld, o_dat,
    input  ram_dout, o_rdy
  );

  modport slave (
    input  ram_cs, ram_we, ram_addr, o_vld, o_dat,
    output ram_dout, o_rdy
  );
endinterface

// File: rtl/acc_sram_rd_streamer.sv
// acc_sram_rd_streamer: walks an address range in a one-cycle-latency SRAM and
// streams the words out over valid/ready, absorbing the read latency in a
// 2-entry buffer so backpressure never loses or duplicates a word.
// Optional feature macro: ACC_RD_STRIDE_EN adds the stride port; without it
// the address advances by one word per read.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// RUN   | issuing reads and popping words until len words are handed off
// FIN   | one-cycle done pulse, then back to IDLE
module acc_sram_rd_streamer #(
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
`ifdef ACC_RD_STRIDE_EN
  input  logic [AW-1:0] stride,
`endif
  output logic          busy,
  output logic          done,
  acc_sram_rd_streamer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] iss_rem, pop_rem;
  logic [AW-1:0] nxt_addr, step;
  logic          inflight;
  logic          pop, issue, accept;
  logic [2:0]    occ;

  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;

`ifdef ACC_RD_STRIDE_EN
  logic [AW-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = {{(AW-1){1'b0}}, 1'b1};
`endif

  assign accept = (state == IDLE) && start;
  assign pop    = bus.o_vld && bus.o_rdy;
  // A word popped this cycle frees its slot in time for a read issued now.
  assign occ    = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign bus.o_vld    = (fifo_cnt != 2'd0);
  assign bus.o_dat    = fifo_mem[rd_ptr];
  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = nxt_addr;
  assign bus.ram_cs   = issue;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode, read issue and status outputs.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? FIN : RUN;
      end
      RUN: begin
        busy  = 1'b1;
        issue = (iss_rem != '0) && (occ < 3'd2);
        if (pop && (pop_rem == LW'(1))) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer counters, address walk and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_rem  <= '0;
      pop_rem  <= '0;
      nxt_addr <= '0;
      inflight <= 1'b0;
`ifdef ACC_RD_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      inflight <= issue;
      if (accept) begin
        iss_rem  <= len;
        pop_rem  <= len;
        nxt_addr <= base_addr;
`ifdef ACC_RD_STRIDE_EN
        stride_q <= stride;
`endif
      end else begin
        if (issue) begin
          nxt_addr <= nxt_addr + step;
          iss_rem  <= iss_rem - LW'(1);
        end
        if (pop) pop_rem <= pop_rem - LW'(1);
      end
    end
  end

  // 2-entry circular buffer: the read returning this cycle is written while
  // the head may be popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= bus.ram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // The issue throttle guarantees a returning read always has a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight && !pop && (fifo_cnt == 2'd2)));

endmodule

// File: tb/tb_acc_sram_rd_streamer.sv
// Self-checking bench for acc_sram_rd_streamer: registered RAM model,
// address/data scoreboard queues filled at start and drained by the monitor.
module tb_acc_sram_rd_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] len;
  logic [15:0] stride;
  logic        busy, done;

  acc_sram_rd_streamer_if #(.AW(16), .DW(64)) bus();

  acc_sram_rd_streamer #(.AW(16), .DW(64), .LW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef ACC_RD_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int rdy_mode = 0;

  logic [15:0] addr_q[$];
  logic [63:0] exp_q[$];

  int n_cs, n_cs_early, n_vld, n_pop, n_done, n_exp;
  int first_cs, last_cs, first_vld, last_pop, done_cyc;
  bit hold;
  logic [63:0] hold_dat;

  function automatic logic [63:0] data_fn(input logic [15:0] a);
    return {16'hC0DE, a, ~a, a ^ 16'h5A5A};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_cs = 0; n_cs_early = 0; n_vld = 0; n_pop = 0; n_done = 0;
    first_cs = -1; last_cs = -1; first_vld = -1; last_pop = -1; done_cyc = -1;
  endtask

  always @(posedge clk) cyc++;

  // Registered-read RAM model.
  always @(posedge clk) begin
    if (bus.ram_cs) bus.ram_dout <= data_fn(bus.ram_addr);
  end

  // Downstream ready pattern.
  initial begin
    bus.o_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.o_rdy = 1'b1;
        1: bus.o_rdy = !((cyc - t0) >= 3 && (cyc - t0) <= 8);
        2: bus.o_rdy = 1'($urandom_range(0, 1));
        default: bus.o_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: address order, data order, hold stability, done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_cs) begin
        n_cs++;
        if (first_cs < 0) first_cs = cyc - t0;
        last_cs = cyc - t0;
        if (cyc - t0 <= 8) n_cs_early++;
        check("ram_we", bus.ram_we, 0);
        if (addr_q.size() == 0) check("extra_cs", n_cs, n_exp);
        else check("ram_addr", bus.ram_addr, addr_q.pop_front());
      end
      if (bus.o_vld) begin
        n_vld++;
        if (first_vld < 0) first_vld = cyc - t0;
      end
      if (hold) begin
        check("vld_hold", bus.o_vld, 1);
        check("dat_hold", bus.o_dat, hold_dat);
      end
      if (bus.o_vld && bus.o_rdy) begin
        n_pop++;
        last_pop = cyc - t0;
        if (exp_q.size() == 0) check("extra_pop", n_pop, n_exp);
        else check("o_dat", bus.o_dat, exp_q.pop_front());
      end
      hold     = bus.o_vld && !bus.o_rdy;
      hold_dat = bus.o_dat;
      if (done) begin
        n_done++;
        done_cyc = cyc - t0;
        check("busy_at_done", busy, 1);
      end
    end else begin
      hold = 1'b0;
    end
  end

  task automatic xfer(input logic [15:0] base, input int n, input logic [15:0] strd,
                      input int mode, input bit spur);
    logic [15:0] step, a;
    int guard;
`ifdef ACC_RD_STRIDE_EN
    step = strd;
`else
    step = 16'd1;
`endif
    clr_stats();
    n_exp = n;
    for (int i = 0; i < n; i++) begin
      a = 16'(base + 16'(i) * step);
      addr_q.push_back(a);
      exp_q.push_back(data_fn(a));
    end
    rdy_mode = mode;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; base_addr = base; len = 16'(n); stride = strd;
    guard = 0;
    while (n_done == 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
      base_addr = 16'h4321; len = 16'd9; stride = 16'd5;
      start = spur && n > 0 && (cyc == t0 + 2 || cyc == t0 + 3 + n);
    end
    start = 1'b0;
    check("done_seen", n_done, 1);
    @(negedge clk);
    check("busy_after_fin", busy, 0);
    check("done_one_shot", done, 0);
    repeat (4) @(posedge clk);
    #1;
    check("n_cs", n_cs, n);
    check("n_pop", n_pop, n);
    check("n_done", n_done, 1);
    check("addr_q_left", addr_q.size(), 0);
    check("exp_q_left", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; stride = '0;
    clr_stats();
    n_exp = 0;
    hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", bus.ram_cs, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_vld", bus.o_vld, 0);
    check("rst_dat", bus.o_dat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic len=4, ready high, with start pulses during RUN and FIN.
    xfer(16'h0010, 4, 16'd1, 0, 1'b1);
    check("t1_first_cs", first_cs, 1);
    check("t1_last_cs", last_cs, 4);
    check("t1_first_vld", first_vld, 3);
    check("t1_last_pop", last_pop, 6);
    check("t1_done", done_cyc, 7);

    // Backpressure T+3..T+8.
    xfer(16'h0010, 4, 16'd1, 1, 1'b0);
    check("t2_cs_before_stall", n_cs_early, 2);
    check("t2_first_vld", first_vld, 3);
    check("t2_last_pop", last_pop, 12);
    check("t2_done", done_cyc, 13);

    // Random ready, 64 words.
    xfer(16'h0100, 64, 16'd1, 2, 1'b0);

    // Address wrap.
    xfer(16'hFFFE, 4, 16'd1, 0, 1'b0);
    check("t4_done", done_cyc, 7);

    // Empty transfer.
    xfer(16'h0055, 0, 16'd1, 0, 1'b0);
    check("t5_done", done_cyc, 1);
    check("t5_no_vld", n_vld, 0);

`ifdef ACC_RD_STRIDE_EN
    xfer(16'h0040, 3, 16'd3, 0, 1'b0);
    check("t6_done", done_cyc, 6);
`endif

    // Reset with one word buffered and one read in flight.
    clr_stats();
    n_exp = 8;
    for (int i = 0; i < 8; i++) begin
      addr_q.push_back(16'(16'h0200 + i));
      exp_q.push_back(data_fn(16'(16'h0200 + i)));
    end
    rdy_mode = 3;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1; base_addr = 16'h0200; len = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 3) begin @(posedge clk); #1; end
    check("t7_vld_before_rst", bus.o_vld, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_busy", busy, 0);
    check("t7_done", done, 0);
    check("t7_cs", bus.ram_cs, 0);
    check("t7_addr", bus.ram_addr, 0);
    check("t7_vld", bus.o_vld, 0);
    check("t7_dat", bus.o_dat, 0);
    addr_q.delete();
    exp_q.delete();
    clr_stats();
    n_exp = 0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t7_no_vld_after", n_vld, 0);
    check("t7_no_cs_after", n_cs, 0);
    check("t7_busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
